systolic_feed_sched: RTL and testbench

Sequencing controller for one systolic-array tile pass. It accepts a start command with a reduction length K and clears the PE accumulators. It then issues K operand-buffer reads whose data enters the per-row/per-column skew buffers, waits for the skewed wavefront to drain through the array, and streams the ROWS result words out under a valid/ready handshake. It sits between the layer-level control FSM and the operand buffers, skew buffers and PE grid.

---
 rtl/systolic_feed_sched_pkg.sv | 23 ++
 rtl/sched_counter.sv | 30 +++
 rtl/systolic_feed_sched.sv | 142 ++++++++++++++
 tb/tb_systolic_feed_sched.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/systolic_feed_sched_pkg.sv
// Shared types and timing helpers for the systolic tile feed scheduler.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package systolic_feed_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    READOUT,
    DONE
  } sched_state_e;

  // Cycles from the last operand read until the final PE has produced its result:
  // buffer read latency, row and column skew of the wavefront, then the MAC pipeline.
  // The skew-buffer instantiation calls this same function so both sides agree.
  function automatic int drain_cycles(input int rows, input int cols,
                                      input int rd_lat, input int pe_lat);
    return rd_lat + (rows - 1) + (cols - 1) + pe_lat;
  endfunction

endpackage

// File: rtl/sched_counter.sv
// Loadable down-counter with terminal-count flag, shared by the FEED and DRAIN phases.
// Latency: load and decrement take effect on the next clock; tc decodes the count directly.
// Backpressure: none; counts only while en=1 and saturates at zero.
module sched_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count;

  // Load has priority; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !tc) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/systolic_feed_sched.sv
// Sequences one systolic tile pass: clear, K operand reads, wavefront drain, ROWS result words.
// Latency: start to first result word is K + DRAIN_CYC + 2 cycles; done one cycle after the last word.
// Backpressure: result words advance only on out_valid_o && out_ready_i; starts are taken only in IDLE.
module systolic_feed_sched
  import systolic_feed_sched_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_MAX  = 256,
  parameter int RD_LAT = 1,
  parameter int PE_LAT = 1,
  localparam int KW    = $clog2(K_MAX + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_async_i,
  input  logic                    start_i,
  input  logic [KW-1:0]           k_len_i,
  output logic                    ready_o,
  output logic                    busy_o,
  output logic                    acc_clr_o,
  output logic                    rd_en_o,
  output logic [KW-1:0]           rd_addr_o,
  output logic                    feed_valid_o,
  output logic                    out_valid_o,
  output logic [$clog2(ROWS)-1:0] out_row_o,
  input  logic                    out_ready_i,
  output logic                    done_o
);

  localparam int DRAIN_CYC = drain_cycles(ROWS, COLS, RD_LAT, PE_LAT);
  // The shared counter must hold both K-1 and DRAIN_CYC-1.
  localparam int CNT_MAX   = (K_MAX > DRAIN_CYC) ? K_MAX : DRAIN_CYC;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int RW        = $clog2(ROWS);

  sched_state_e  state, state_next;
  logic          k_ok;
  logic          cnt_load;
  logic [CW-1:0] cnt_load_val;
  logic          cnt_en;
  logic          cnt_tc;

  assign k_ok = (k_len_i != '0) && (k_len_i <= KW'(K_MAX));

  // State register; reset abandons any pass in flight.
  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and phase-counter control. The counter latches K-1 at acceptance,
  // holds it through CLEAR, then is reloaded with the drain length at the end of FEED.
  always_comb begin
    state_next   = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state)
      IDLE: begin
        if (start_i && k_ok) begin
          state_next   = CLEAR;
          cnt_load     = 1'b1;
          cnt_load_val = CW'(k_len_i) - CW'(1);
        end
      end
      CLEAR:   state_next = FEED;
      FEED: begin
        if (cnt_tc) begin
          state_next   = DRAIN;
          cnt_load     = 1'b1;
          cnt_load_val = CW'(DRAIN_CYC - 1);
        end
      end
      DRAIN: begin
        if (cnt_tc) state_next = READOUT;
      end
      READOUT: begin
        if (out_ready_i && (out_row_o == RW'(ROWS - 1))) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign cnt_en = (state == FEED) || (state == DRAIN);

  sched_counter #(.W(CW)) u_phase_cnt (
    .clk      (clk_i),
    .rst      (rst_async_i),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .tc       (cnt_tc)
  );

  // Read address walks 0..K-1 during FEED and parks at 0 otherwise, so it never wraps.
  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      rd_addr_o <= '0;
    end else if (state == FEED) begin
      rd_addr_o <= cnt_tc ? '0 : rd_addr_o + KW'(1);
    end
  end

  // Result row index advances only on an accepted transfer and returns to 0 after the last row.
  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      out_row_o <= '0;
    end else if ((state == READOUT) && out_ready_i) begin
      out_row_o <= (out_row_o == RW'(ROWS - 1)) ? '0 : out_row_o + RW'(1);
    end
  end

  assign ready_o     = (state == IDLE);
  assign busy_o      = !ready_o;
  assign acc_clr_o   = (state == CLEAR);
  assign rd_en_o     = (state == FEED);
  assign out_valid_o = (state == READOUT);
  assign done_o      = (state == DONE);

  // feed_valid_o tracks rd_en_o through the operand-buffer read latency.
  generate
    if (RD_LAT == 0) begin : g_fv_comb
      assign feed_valid_o = rd_en_o;
    end else begin : g_fv_pipe
      logic [RD_LAT-1:0] fv_sr;
      // Shift register aligning the qualifier with returned read data.
      always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
          fv_sr <= '0;
        end else begin
          fv_sr[0] <= rd_en_o;
          for (int i = 1; i < RD_LAT; i++) fv_sr[i] <= fv_sr[i-1];
        end
      end
      assign feed_valid_o = fv_sr[RD_LAT-1];
    end
  endgenerate

endmodule

// File: tb/tb_systolic_feed_sched.sv
// Directed bench for systolic_feed_sched with 4x4 array, RD_LAT=1, PE_LAT=1 (drain of 8 cycles).
// Latency: cycle c is the clock period following edge c-1; outputs sampled on the falling edge.
// Backpressure: out_ready driven per cycle from a stall mask.
module tb_systolic_feed_sched;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int K_MAX  = 256;
  localparam int RD_LAT = 1;
  localparam int PE_LAT = 1;
  localparam int D      = 8;  // 1 + 3 + 3 + 1
  localparam logic [17:0] RST_VEC = 18'h20000;  // ready=1, everything else 0

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [8:0] k_len = '0;
  logic       out_ready = 1'b1;
  logic       ready, busy, acc_clr, rd_en, feed_valid, out_valid, done;
  logic [8:0] rd_addr;
  logic [1:0] out_row;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  systolic_feed_sched #(
    .ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .RD_LAT(RD_LAT), .PE_LAT(PE_LAT)
  ) dut (
    .clk_i        (clk),
    .rst_async_i  (rst),
    .start_i      (start),
    .k_len_i      (k_len),
    .ready_o      (ready),
    .busy_o       (busy),
    .acc_clr_o    (acc_clr),
    .rd_en_o      (rd_en),
    .rd_addr_o    (rd_addr),
    .feed_valid_o (feed_valid),
    .out_valid_o  (out_valid),
    .out_row_o    (out_row),
    .out_ready_i  (out_ready),
    .done_o       (done)
  );

  function automatic logic [17:0] snap();
    return {ready, busy, acc_clr, rd_en, feed_valid, out_valid, done, rd_addr, out_row};
  endfunction

  task automatic check(input string tag, input int cyc, input logic [17:0] obs, input logic [17:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One full pass started in cycle 0; exp_done is the hand-derived done cycle.
  task automatic run_pass(input string tag, input int k, input logic [63:0] stall, input int exp_done);
    int ro, row, nrd, last_addr;
    logic e_rd, e_val, e_idle;
    logic [17:0] e, o;
    ro = k + 2 + D;
    row = 0;
    nrd = 0;
    last_addr = -1;
    for (int c = 0; c <= exp_done + 1; c++) begin
      @(negedge clk);
      start     = (c == 0);
      k_len     = 9'(k);
      out_ready = !(c < 64 && stall[c]);
      e_idle = (c == 0) || (c > exp_done);
      e_rd   = (c >= 2) && (c <= k + 1);
      e_val  = (c >= ro) && (c < exp_done);
      e = {e_idle, !e_idle, c == 1, e_rd, (c >= 3) && (c <= k + 2), e_val, c == exp_done,
           e_rd ? 9'(c - 2) : 9'd0, e_val ? 2'(row) : 2'd0};
      o = {ready, busy, acc_clr, rd_en, feed_valid, out_valid, done,
           e_rd ? rd_addr : 9'd0, e_val ? out_row : 2'd0};
      check(tag, c, o, e);
      if (rd_en) begin
        nrd++;
        last_addr = int'(rd_addr);
      end
      if (e_val && out_ready) row++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check({tag, "_rd_cnt"}, exp_done, 18'(nrd), 18'(k));
    check({tag, "_last_addr"}, exp_done, 18'(last_addr), 18'(k - 1));
    check({tag, "_rows"}, exp_done, 18'(row), 18'(ROWS));
  endtask

  initial begin
    int clr_cyc[$];
    logic prev_ready;

    // Reset held across two edges.
    repeat (2) @(negedge clk);
    check("reset", 0, snap(), RST_VEC);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset", 0, snap(), RST_VEC);

    // Nominal pass: K=8, consumer always ready.
    run_pass("k8", 8, 64'h0, 22);

    // Backpressure: stalls on cycles 18,19,20 and 23.
    run_pass("bp", 8, 64'h0000_0000_009C_0000, 26);

    // Illegal lengths are ignored.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start = 1'b1;
      k_len = 9'd0;
      check("k0_ignored", c, {11'd0, ready, busy, acc_clr, rd_en, feed_valid, out_valid, done}, 18'h40);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start = 1'b1;
      k_len = 9'd257;
      check("k257_ignored", c, {11'd0, ready, busy, acc_clr, rd_en, feed_valid, out_valid, done}, 18'h40);
    end
    @(negedge clk);
    start = 1'b0;

    // Back-to-back with start held high, K=1: pass length 1+8+4+3 = 16 cycles.
    prev_ready = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b1;
      k_len = 9'd1;
      check("b2b_busy", c, 18'(busy), 18'(!ready));
      if (acc_clr) begin
        clr_cyc.push_back(c);
        check("b2b_accept_idle", c, 18'(prev_ready), 18'd1);
      end
      prev_ready = ready;
    end
    start = 1'b0;
    check("b2b_passes", 40, 18'(clr_cyc.size()), 18'd3);
    if (clr_cyc.size() >= 3) begin
      check("b2b_clr0", 0, 18'(clr_cyc[0]), 18'd1);
      check("b2b_clr1", 0, 18'(clr_cyc[1]), 18'd17);
      check("b2b_clr2", 0, 18'(clr_cyc[2]), 18'd33);
    end
    repeat (12) @(negedge clk);
    check("b2b_idle", 0, 18'(ready), 18'd1);

    // Longest pass: K=256, done at 256+8+4+2.
    run_pass("k256", 256, 64'h0, 270);

    // Reset during FEED at rd_addr=3 (cycle 5).
    @(negedge clk);
    start = 1'b1;
    k_len = 9'd8;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_feed", 5, {7'd0, rd_en, rd_addr, 1'b0}, {7'd0, 1'b1, 9'd3, 1'b0});
    rst = 1'b1;
    #1;
    check("rst_feed_async", 5, snap(), RST_VEC);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("after_rst_feed", c, snap(), RST_VEC);
    end

    // Reset during READOUT (cycle 19, row 1 after one transfer).
    @(negedge clk);
    start = 1'b1;
    k_len = 9'd8;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_ro", 19, {7'd0, out_valid, 8'd0, out_row}, {7'd0, 1'b1, 8'd0, 2'd1});
    rst = 1'b1;
    #1;
    check("rst_ro_async", 19, snap(), RST_VEC);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("after_rst_ro", c, snap(), RST_VEC);
    end

    // Clean pass after reset must match the nominal pass.
    run_pass("k8_after_rst", 8, 64'h0, 22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
